stack_sequencer: RTL and testbench

//  Command-driven initiator for the processor's LIFO stack: drives push/pop/data_in, reads data_out/full/empty.

---
 rtl/stack_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Command-driven initiator for the processor's LIFO stack. It accepts RPN
// commands from instruction decode and turns each one into a short sequence
// of push/pop strobes on the stack. Push and pop are never asserted together.
//
// Commands (cmd_op):
//   000 NOP   - accepted, nothing happens
//   001 PUSH  - push cmd_imm (overflow error if the stack is full)
//   010 POP   - pop top into result (underflow error if empty)
//   011 ADD   - B + A
//   100 SUB   - B - A
//   101 AND   - B & A
//   110 OR    - B | A
//   111 MUL   - low width bits of B * A when STACK_SEQ_MUL_EN is defined,
//               otherwise an illegal opcode (err_code 11, no stack access)
//   A is the former top of stack, B the entry below it. Binary ops pop both
//   operands and push the result. If only one entry exists, it is pushed back
//   and an underflow error is reported, so the stack is unchanged.
//
// Build option:
//   STACK_SEQ_MUL_EN - enables the MUL opcode (and the multiplier).
//
// Ports:
//   clk           clock, all state on rising edge
//   resetN        asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_op        opcode
//   cmd_imm       immediate for PUSH
//   stk_push      push strobe to stack
//   stk_pop       pop strobe to stack
//   stk_data_in   value to push
//   stk_data_out  stack output register, valid the cycle after a pop
//   stk_full      stack full
//   stk_empty     stack empty
//   result        last popped / computed value
//   result_valid  one-cycle pulse, result updated
//   err           one-cycle pulse, command aborted
//   err_code      01 underflow, 10 overflow, 11 illegal op; held until next err
// -----------------------------------------------------------------------------
module stack_sequencer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [width-1:0] cmd_imm,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [width-1:0] stk_data_in,
  input  logic [width-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [width-1:0] result,
  output logic             result_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POPW,
    S_POPA,
    S_POPB,
    S_EXEC,
    S_RESTORE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [2:0]       op_q;
  logic [width-1:0] imm_q;
  logic [width-1:0] opa_q;

  logic             accept;
  logic             opa_ld;
  logic             res_ld;
  logic [width-1:0] res_nxt;
  logic             err_set;
  logic [1:0]       err_code_nxt;

  // Binary ALU: b is the deeper entry, a the former top. Wraps mod 2^width.
  function automatic logic [width-1:0] alu_f(input logic [2:0]       op,
                                             input logic [width-1:0] b,
                                             input logic [width-1:0] a);
    logic [width-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = b + a;
      OP_SUB:  r = b - a;
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
`ifdef STACK_SEQ_MUL_EN
      OP_MUL:  r = b * a;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Next state, strobes and register-load controls. Strobes depend only on
  // the current state and the stack status flags, never on the command inputs.
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_data_in  = '0;
    accept       = 1'b0;
    opa_ld       = 1'b0;
    res_ld       = 1'b0;
    res_nxt      = '0;
    err_set      = 1'b0;
    err_code_nxt = ERR_UNDER;

    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          case (cmd_op)
            OP_NOP:  state_nxt = S_IDLE;
            OP_PUSH: state_nxt = S_PUSH;
            OP_POP:  state_nxt = S_POP;
            OP_ADD:  state_nxt = S_POPA;
            OP_SUB:  state_nxt = S_POPA;
            OP_AND:  state_nxt = S_POPA;
            OP_OR:   state_nxt = S_POPA;
            OP_MUL: begin
`ifdef STACK_SEQ_MUL_EN
              state_nxt = S_POPA;
`else
              // Reported straight from IDLE so the pulse lands one cycle
              // after accept without touching the stack.
              err_set      = 1'b1;
              err_code_nxt = ERR_ILLEGAL;
`endif
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end

      S_PUSH: begin
        if (stk_full) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_OVER;
        end else begin
          stk_push    = 1'b1;
          stk_data_in = imm_q;
        end
        state_nxt = S_IDLE;
      end

      S_POP: begin
        if (stk_empty) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_UNDER;
          state_nxt    = S_IDLE;
        end else begin
          stk_pop   = 1'b1;
          state_nxt = S_POPW;
        end
      end

      S_POPW: begin
        res_ld    = 1'b1;
        res_nxt   = stk_data_out;
        state_nxt = S_IDLE;
      end

      S_POPA: begin
        if (stk_empty) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_UNDER;
          state_nxt    = S_IDLE;
        end else begin
          stk_pop   = 1'b1;
          state_nxt = S_POPB;
        end
      end

      S_POPB: begin
        // stk_data_out now holds A; keep it while B is popped.
        opa_ld = 1'b1;
        if (stk_empty) begin
          state_nxt = S_RESTORE;
        end else begin
          stk_pop   = 1'b1;
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        stk_push    = 1'b1;
        stk_data_in = alu_f(op_q, stk_data_out, opa_q);
        res_ld      = 1'b1;
        res_nxt     = stk_data_in;
        state_nxt   = S_IDLE;
      end

      S_RESTORE: begin
        // Only one operand was present: put it back so the net effect on the
        // stack is nil, then report underflow.
        stk_push     = 1'b1;
        stk_data_in  = opa_q;
        err_set      = 1'b1;
        err_code_nxt = ERR_UNDER;
        state_nxt    = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- control / status registers (async reset) ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      op_q         <= OP_NOP;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      state        <= state_nxt;
      result_valid <= res_ld;
      err          <= err_set;
      if (accept)  op_q     <= cmd_op;
      if (res_ld)  result   <= res_nxt;
      if (err_set) err_code <= err_code_nxt;
    end
  end

  // ---- operand holding registers (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) imm_q <= cmd_imm;
    if (opa_ld) opa_q <= stk_data_out;
  end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out = 8'h00;
  logic       stk_full;
  logic       stk_empty;
  logic [7:0] result;
  logic       result_valid;
  logic       err;
  logic [1:0] err_code;

  int errors = 0;
  int checks = 0;

  // Behavioural 4-deep stack with registered output.
  logic [7:0] mem [0:3];
  int         sp = 0;
  logic       stk_clr = 1'b0;

  assign stk_full  = (sp == 4);
  assign stk_empty = (sp == 0);

  always @(posedge clk) begin
    if (stk_clr) begin
      sp <= 0;
    end else if (stk_push && !stk_full) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_pop && !stk_empty) begin
      stk_data_out <= mem[sp-1];
      sp           <= sp - 1;
    end
  end

  stack_sequencer #(.width(8)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_imm      (cmd_imm),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Every cycle: push/pop exclusive, err/result_valid exclusive.
  always @(negedge clk) begin
    checks++;
    assert (!(stk_push && stk_pop)) else begin
      errors++;
      $error("FAIL push_pop_excl: observed push=%0b pop=%0b required not both", stk_push, stk_pop);
    end
    checks++;
    assert (!(err && result_valid)) else begin
      errors++;
      $error("FAIL err_rv_excl: observed err=%0b rv=%0b required not both", err, result_valid);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Per-command observations, k = cycles after the accept edge.
  int         k_push, k_rv, k_err, k_rdy, n_push, n_pop;
  logic [7:0] push_val;

  task automatic issue(input logic [2:0] op, input logic [7:0] imm);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    k_push = 0; k_rv = 0; k_err = 0; k_rdy = 0; n_push = 0; n_pop = 0;
    push_val = 8'h00;
    for (int k = 1; k <= 10 && k_rdy == 0; k++) begin
      @(negedge clk);
      if (stk_push) begin
        n_push++;
        if (k_push == 0) begin
          k_push   = k;
          push_val = stk_data_in;
        end
      end
      if (stk_pop) n_pop++;
      if (result_valid && k_rv == 0) k_rv = k;
      if (err && k_err == 0) k_err = k;
      if (cmd_ready) k_rdy = k;
    end
    chk("done_timeout", (k_rdy != 0), 1'b1);
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] imm);
    issue(op, imm);
    wait_done();
  endtask

  task automatic clear_stack();
    stk_clr = 1'b1;
    @(posedge clk);
    #1;
    stk_clr = 1'b0;
  endtask

  initial begin
    resetN    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_imm   = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_push", stk_push, 1'b0);
    chk("rst_pop", stk_pop, 1'b0);
    chk("rst_din", stk_data_in, 8'h00);
    chk("rst_result", result, 8'h00);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_errcode", err_code, 2'b00);
    resetN = 1'b1;
    @(negedge clk);

    // PUSH 5, PUSH 3, ADD -> 8
    run(3'b001, 8'd5);
    chk("push_lat", k_push, 1);
    chk("push_val", push_val, 8'd5);
    chk("push_ready", k_rdy, 2);
    run(3'b001, 8'd3);
    run(3'b011, 8'h00);
    chk("add_push_lat", k_push, 3);
    chk("add_push_val", push_val, 8'd8);
    chk("add_rv_lat", k_rv, 4);
    chk("add_ready", k_rdy, 4);
    chk("add_result", result, 8'd8);
    chk("add_npop", n_pop, 2);
    chk("add_sp", sp, 1);
    chk("add_top", mem[0], 8'd8);
    chk("add_noerr", k_err, 0);

    // POP -> 8
    run(3'b010, 8'h00);
    chk("pop_rv_lat", k_rv, 3);
    chk("pop_ready", k_rdy, 3);
    chk("pop_result", result, 8'd8);
    chk("pop_sp", sp, 0);

    // PUSH 3, PUSH 5, SUB -> 3-5 = FE
    run(3'b001, 8'd3);
    run(3'b001, 8'd5);
    run(3'b100, 8'h00);
    chk("sub_result", result, 8'hFE);
    chk("sub_top", mem[0], 8'hFE);
    clear_stack();

    // PUSH 200, PUSH 100, ADD -> 300 mod 256 = 2C
    run(3'b001, 8'd200);
    run(3'b001, 8'd100);
    run(3'b011, 8'h00);
    chk("addwrap_result", result, 8'h2C);
    clear_stack();

    // AND / OR
    run(3'b001, 8'hF0);
    run(3'b001, 8'h3C);
    run(3'b101, 8'h00);
    chk("and_result", result, 8'h30);
    run(3'b001, 8'h0F);
    run(3'b110, 8'h00);
    chk("or_result", result, 8'h3F);
    chk("or_sp", sp, 1);
    clear_stack();

    // NOP: no pulses, ready immediately
    run(3'b000, 8'h00);
    chk("nop_ready", k_rdy, 1);
    chk("nop_pulses", (k_rv != 0) || (k_err != 0) || (n_push != 0) || (n_pop != 0), 1'b0);

    // Empty POP -> underflow, no pop strobe
    run(3'b010, 8'h00);
    chk("pop_uf_err_lat", k_err, 2);
    chk("pop_uf_code", err_code, 2'b01);
    chk("pop_uf_npop", n_pop, 0);
    chk("pop_uf_norv", k_rv, 0);

    // One entry then ADD -> underflow, entry restored
    run(3'b001, 8'h55);
    run(3'b011, 8'h00);
    chk("bin_uf_err_lat", k_err, 4);
    chk("bin_uf_code", err_code, 2'b01);
    chk("bin_uf_npop", n_pop, 1);
    chk("bin_uf_npush", n_push, 1);
    chk("bin_uf_norv", k_rv, 0);
    chk("bin_uf_sp", sp, 1);
    chk("bin_uf_top", mem[0], 8'h55);
    run(3'b010, 8'h00);
    chk("bin_uf_pop_back", result, 8'h55);

    // Fill, then PUSH 9 -> overflow, no push strobe
    run(3'b001, 8'd1);
    run(3'b001, 8'd2);
    run(3'b001, 8'd3);
    run(3'b001, 8'd4);
    chk("fill_full", stk_full, 1'b1);
    run(3'b001, 8'd9);
    chk("ovf_err_lat", k_err, 2);
    chk("ovf_code", err_code, 2'b10);
    chk("ovf_npush", n_push, 0);
    chk("ovf_sp", sp, 4);
    run(3'b010, 8'h00);
    chk("ovf_pop_top", result, 8'd4);
    chk("errcode_held", err_code, 2'b10);
    clear_stack();

    // Op 111 with 6, 7 on the stack
    run(3'b001, 8'd6);
    run(3'b001, 8'd7);
    run(3'b111, 8'h00);
`ifdef STACK_SEQ_MUL_EN
    chk("mul_result", result, 8'd42);
    chk("mul_rv_lat", k_rv, 4);
    chk("mul_sp", sp, 1);
`else
    chk("ill_err_lat", k_err, 1);
    chk("ill_code", err_code, 2'b11);
    chk("ill_nacc", n_push + n_pop, 0);
    chk("ill_sp", sp, 2);
    chk("ill_top", mem[1], 8'd7);
`endif
    clear_stack();

    // Reset asserted while ADD sits in POPB
    run(3'b001, 8'd1);
    run(3'b001, 8'd2);
    issue(3'b011, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("popb_pop", stk_pop, 1'b1);
    resetN = 1'b0;
    #1;
    chk("mid_rst_pop", stk_pop, 1'b0);
    chk("mid_rst_push", stk_push, 1'b0);
    chk("mid_rst_din", stk_data_in, 8'h00);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_errcode", err_code, 2'b00);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    wait_done();
    chk("post_rst_ready", k_rdy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {stk_push, stk_pop, err, result_valid}, 4'b0000);
    end
    chk("post_rst_sp", sp, 1);
    run(3'b010, 8'h00);
    chk("post_rst_pop", result, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
